// File: rtl/dmem_responder.sv
// Data-memory responder: fixed wait-state handshake in front of a word RAM.
// Define DMEM_IO_EN to add the GPIO / cycle-counter region at IO_BASE.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] IO_BASE     = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_dm_M,
  input  logic        dm2reg_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] wd_dm_M,
  output logic [31:0] rd_dm,
  output logic        stall_mem,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          req, completing, fire, store_fire, ram_sel;
  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   ram_rdata, io_rdata, load_data;
  logic [AW-1:0] word_idx;
  logic          unused_ok;

  assign req        = we_dm_M | dm2reg_M;
  assign word_idx   = alu_out_M[AW+1:2];
  assign completing = (state == S_READY) || ((WAIT_STATES == 0) && (state == S_IDLE));
  // Reset gates the handshake so an access in flight during reset never commits.
  assign fire       = rst & req & completing;
  assign store_fire = fire & we_dm_M;
  assign stall_mem  = rst & req & ~completing;
  assign rd_dm      = (fire && !we_dm_M) ? load_data : 32'h0;
  assign unused_ok  = ^{alu_out_M, gpio_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 1) begin
            state_next = S_READY;
          end else if (WAIT_STATES >= 2) begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_next = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_next = S_READY;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_READY: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_fire && ram_sel) begin
      ram[word_idx] <= wd_dm_M;
    end
  end

  assign ram_rdata = ram[word_idx];
  assign load_data = ram_sel ? ram_rdata : io_rdata;

`ifdef DMEM_IO_EN
  logic [29:0] io_off;
  logic [31:0] gpio_sync1, gpio_sync2, cycle_cnt;

  assign ram_sel = alu_out_M < IO_BASE;
  assign io_off  = alu_out_M[31:2] - IO_BASE[31:2];

  always_comb begin
    io_rdata = 32'h0;
    case (io_off)
      30'd0:   io_rdata = gpio_out;
      30'd1:   io_rdata = gpio_sync2;
      30'd2:   io_rdata = cycle_cnt;
      default: io_rdata = 32'h0;
    endcase
  end

  // A store to the counter overrides that cycle's increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out   <= 32'h0;
      gpio_sync1 <= 32'h0;
      gpio_sync2 <= 32'h0;
      cycle_cnt  <= 32'h0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (store_fire && !ram_sel && io_off == 30'd2) begin
        cycle_cnt <= 32'h0;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (store_fire && !ram_sel && io_off == 30'd0) begin
        gpio_out <= wd_dm_M;
      end
    end
  end
`else
  assign ram_sel  = 1'b1;
  assign io_rdata = 32'h0;
  assign gpio_out = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances with WAIT_STATES 2, 0, 1, 3
// driven from a per-cycle vector table plus hand-written flush/reset/IO sequences.
module tb_dmem_responder;
  localparam logic [31:0] IO_BASE = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we [4];
  logic        ld [4];
  logic [31:0] addr [4];
  logic [31:0] wd [4];
  logic [31:0] rd [4];
  logic        stall [4];
  logic [31:0] gout [4];
  logic [31:0] gin;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int          d;
    logic        we;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        stall;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2), .IO_BASE(IO_BASE)) u_ws2 (
    .clk(clk), .rst(rst_n), .we_dm_M(we[0]), .dm2reg_M(ld[0]), .alu_out_M(addr[0]),
    .wd_dm_M(wd[0]), .rd_dm(rd[0]), .stall_mem(stall[0]), .gpio_in(gin), .gpio_out(gout[0]));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .IO_BASE(IO_BASE)) u_ws0 (
    .clk(clk), .rst(rst_n), .we_dm_M(we[1]), .dm2reg_M(ld[1]), .alu_out_M(addr[1]),
    .wd_dm_M(wd[1]), .rd_dm(rd[1]), .stall_mem(stall[1]), .gpio_in(gin), .gpio_out(gout[1]));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1), .IO_BASE(IO_BASE)) u_ws1 (
    .clk(clk), .rst(rst_n), .we_dm_M(we[2]), .dm2reg_M(ld[2]), .alu_out_M(addr[2]),
    .wd_dm_M(wd[2]), .rd_dm(rd[2]), .stall_mem(stall[2]), .gpio_in(gin), .gpio_out(gout[2]));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3), .IO_BASE(IO_BASE)) u_ws3 (
    .clk(clk), .rst(rst_n), .we_dm_M(we[3]), .dm2reg_M(ld[3]), .alu_out_M(addr[3]),
    .wd_dm_M(wd[3]), .rd_dm(rd[3]), .stall_mem(stall[3]), .gpio_in(gin), .gpio_out(gout[3]));

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input int d, input logic w, input logic l,
                                input logic [31:0] a, input logic [31:0] data);
    we[d]   = w;
    ld[d]   = l;
    addr[d] = a;
    wd[d]   = data;
  endtask

  // Samples one cycle at the falling edge, then advances to just after the next rising edge.
  task automatic step_check(input string name, input int d, input logic exp_stall,
                            input logic [31:0] exp_rd);
    @(negedge clk);
    check_output({name, ".stall"}, 32'(stall[d]), 32'(exp_stall));
    check_output({name, ".rd"}, rd[d], exp_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input string name, input int d);
    apply_stimulus(d, 1'b0, 1'b0, 32'h0, 32'h0);
    step_check(name, d, 1'b0, 32'h0);
  endtask

  initial begin
    // WAIT_STATES=2: store then load 0x10
    vecs.push_back('{0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
    // WAIT_STATES=0: store 0x104, load 0x004 aliases the same word
    vecs.push_back('{1, 1'b1, 1'b0, 32'h104, 32'h1234, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 1'b1, 32'h004, 32'h0, 1'b0, 32'h1234});
    vecs.push_back('{1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
    // WAIT_STATES=1: store and load both high is a store
    vecs.push_back('{2, 1'b1, 1'b1, 32'h8, 32'h9, 1'b1, 32'h0});
    vecs.push_back('{2, 1'b1, 1'b1, 32'h8, 32'h9, 1'b0, 32'h0});
    vecs.push_back('{2, 1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{2, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0, 32'h9});
    vecs.push_back('{2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
    // WAIT_STATES=3: seed 0x20 with 0x11
    vecs.push_back('{3, 1'b1, 1'b0, 32'h20, 32'h11, 1'b1, 32'h0});
    vecs.push_back('{3, 1'b1, 1'b0, 32'h20, 32'h11, 1'b1, 32'h0});
    vecs.push_back('{3, 1'b1, 1'b0, 32'h20, 32'h11, 1'b1, 32'h0});
    vecs.push_back('{3, 1'b1, 1'b0, 32'h20, 32'h11, 1'b0, 32'h0});
    vecs.push_back('{3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});

    rst_n = 1'b0;
    gin   = 32'h0;
    for (int i = 0; i < 4; i++) apply_stimulus(i, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Outputs held quiet during reset even with a request present
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'h1);
    @(negedge clk);
    check_output("rst.stall", 32'(stall[0]), 32'h0);
    check_output("rst.rd", rd[0], 32'h0);
    check_output("rst.gpio_out", gout[2], 32'h0);
    apply_stimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].d, vecs[i].we, vecs[i].ld, vecs[i].addr, vecs[i].wd);
      step_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].stall, vecs[i].rd);
    end

    // Flush: store 0x77 dropped after one stall cycle must not commit
    apply_stimulus(3, 1'b1, 1'b0, 32'h20, 32'h77);
    step_check("flush_req", 3, 1'b1, 32'h0);
    idle_step("flush_drop", 3);
    apply_stimulus(3, 1'b0, 1'b1, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) step_check($sformatf("flush_ld%0d", i), 3, 1'b1, 32'h0);
    step_check("flush_ld_done", 3, 1'b0, 32'h11);
    idle_step("flush_idle", 3);

    // Reset asserted while in WAIT abandons the store
    apply_stimulus(3, 1'b1, 1'b0, 32'h20, 32'h55);
    step_check("rstw_req", 3, 1'b1, 32'h0);
    rst_n = 1'b0;
    #1;
    check_output("rstw.stall", 32'(stall[3]), 32'h0);
    check_output("rstw.rd", rd[3], 32'h0);
    @(negedge clk);
    apply_stimulus(3, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(3, 1'b0, 1'b1, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) step_check($sformatf("rstw_ld%0d", i), 3, 1'b1, 32'h0);
    step_check("rstw_ld_done", 3, 1'b0, 32'h11);
    idle_step("rstw_idle", 3);

`ifdef DMEM_IO_EN
    // gpio_out store lands at the completion edge
    apply_stimulus(2, 1'b1, 1'b0, IO_BASE, 32'hA5);
    step_check("gout_c1", 2, 1'b1, 32'h0);
    check_output("gout_pre", gout[2], 32'h0);
    step_check("gout_c2", 2, 1'b0, 32'h0);
    check_output("gout_post", gout[2], 32'hA5);
    gin = 32'h55AA;
    // Store to the gpio_in address is ignored
    apply_stimulus(2, 1'b1, 1'b0, IO_BASE + 32'd4, 32'hFFFF);
    step_check("gin_st1", 2, 1'b1, 32'h0);
    step_check("gin_st2", 2, 1'b0, 32'h0);
    idle_step("gin_idle", 2);
    apply_stimulus(2, 1'b0, 1'b1, IO_BASE + 32'd4, 32'h0);
    step_check("gin_ld1", 2, 1'b1, 32'h0);
    step_check("gin_ld2", 2, 1'b0, 32'h55AA);
    check_output("gout_keep", gout[2], 32'hA5);
    apply_stimulus(2, 1'b0, 1'b1, IO_BASE + 32'd12, 32'h0);
    step_check("unmap_ld1", 2, 1'b1, 32'h0);
    step_check("unmap_ld2", 2, 1'b0, 32'h0);
    // Counter clear, one idle cycle, then load: 0 -> 1 -> 2
    apply_stimulus(2, 1'b1, 1'b0, IO_BASE + 32'd8, 32'h1234);
    step_check("cnt_st1", 2, 1'b1, 32'h0);
    step_check("cnt_st2", 2, 1'b0, 32'h0);
    idle_step("cnt_idle", 2);
    apply_stimulus(2, 1'b0, 1'b1, IO_BASE + 32'd8, 32'h0);
    step_check("cnt_ld1", 2, 1'b1, 32'h0);
    step_check("cnt_ld2", 2, 1'b0, 32'h2);
    apply_stimulus(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    force u_ws1.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release u_ws1.cycle_cnt;
    @(posedge clk);
    #1;
    check_output("cnt_wrap", u_ws1.cycle_cnt, 32'h0);
`else
    // Without I/O the IO_BASE address is plain RAM (0x800 aliases word 0)
    apply_stimulus(2, 1'b1, 1'b0, IO_BASE, 32'hA5);
    step_check("noio_st1", 2, 1'b1, 32'h0);
    step_check("noio_st2", 2, 1'b0, 32'h0);
    apply_stimulus(2, 1'b0, 1'b1, 32'h0, 32'h0);
    step_check("noio_ld1", 2, 1'b1, 32'h0);
    step_check("noio_ld2", 2, 1'b0, 32'hA5);
    check_output("noio_gout", gout[2], 32'h0);
    idle_step("noio_idle", 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
